aes_round_controller: RTL and testbench
=======================================

# aes_round_controller

Iterative AES encryption sequencer. It owns the 128-bit cipher state register and steps one block through the initial AddRoundKey and NR rounds. Each round uses an external combinational round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey). Round keys are fetched from an external key-schedule store through a req/valid handshake, and the ciphertext is delivered on a valid/ready output.

## Interface
- NR, default 10: number of rounds (10/12/14 for AES-128/192/256); round counter is 4 bits.
- clk  in  1  rising-edge clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  controller can accept a block; high only in IDLE.
- in_block  in  128  plaintext, byte 0 at [127:120].
- rk_req  out  1  round-key request; level signal.
- rk_idx  out  4  index of requested round key (0..NR).
- rk_valid  in  1  rk_data holds key rk_idx this cycle.
- rk_data  in  128  round key; the controller also routes it to the datapath key input.
- dp_in  out  128  state presented to the round datapath (equals state_q).
- dp_final  out  1  final round; datapath bypasses MixColumns.
- dp_out  in  128  combinational round result for dp_in, dp_final, rk_data.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes ciphertext.
- out_block  out  128  ciphertext (equals state_q while out_valid).
- busy  out  1  high in every state except IDLE.
- round  out  4  current round counter.

## Operation
- FSM states: IDLE, INIT, ROUND, DONE. Registers: fsm, state_q[127:0], rnd[3:0].
- **IDLE.** in_ready=1.
  - On in_valid&in_ready: state_q←in_block, rnd←0, go to INIT.
- **INIT.** rk_req=1, rk_idx=0.
  - On rk_valid: state_q←state_q^rk_data, rnd←1, go to ROUND.
  - Otherwise hold all registers.
- **ROUND.** rk_req=1, rk_idx=rnd, dp_final=(rnd==NR).
  - On rk_valid: state_q←dp_out.
  - If rnd==NR, go to DONE. Else rnd←rnd+1.
  - Without rk_valid, hold all registers.
- **DONE.** out_valid=1, out_block=state_q.
  - On out_ready: go to IDLE; rnd←0.
  - state_q keeps the ciphertext until the next accept.
- Decoded outputs:
  - round=rnd.
  - rk_req=0 and dp_final=0 outside INIT/ROUND.
  - rk_idx=rnd in every state (0 in IDLE).
- rk_valid is ignored whenever rk_req=0.
- No overlap: a new block is not accepted in the cycle DONE hands off. in_ready rises the cycle after the out_ready handshake.
- in_block is sampled only on the accept edge. Later changes on in_block have no effect.
- rnd never exceeds NR and never wraps.

## Timing
- Reset values: fsm=IDLE, state_q=0, rnd=0.
  - Hence in_ready=1 (first cycle after rst), rk_req=0, rk_idx=0, dp_final=0, out_valid=0, out_block=0, busy=0, round=0.
  - While rst=1, in_valid is not accepted.
- rst asserted in any state aborts the operation within that edge:
  - Back to IDLE; rk_req drops the next cycle.
  - No out_valid is produced for the aborted block.
- rk_req/rk_idx are registered-state decodes and stay stable until rk_valid. rk_valid may arrive in the same cycle as rk_req rises (zero-wait store).
- Latency with zero-wait keys:
  - Accept edge at cycle 0.
  - INIT occupies cycle 1.
  - Rounds 1..NR occupy cycles 2..NR+1.
  - out_valid rises at cycle NR+2 (cycle 12 for NR=10).
  - Each cycle of rk_valid delay adds exactly one cycle.
- Throughput is one block per NR+3 cycles with zero-wait keys and immediate out_ready.
- out_valid holds, with out_block stable, until out_ready. Backpressure never alters state_q.

## Test plan
- **FIPS-197 C.1 vector.** Setup: NR=10; bench key-schedule model with zero-wait rk_valid; reference round datapath. Stimulus: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, out_ready=1. Required: out_block=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 12 cycles after the accept edge; dp_final high only when round=10.
- **Key wait states.** Stimulus: same vector, rk_valid delayed 3 cycles on indices 0, 5 and 10. Required: identical ciphertext; out_valid at cycle 21; rk_idx stable throughout each wait.
- **Output backpressure and back-to-back.** Stimulus: out_ready held low 5 cycles after out_valid, with a second block (all zeros) offered continuously. Required: out_block stable; in_ready stays 0 until the cycle after the out_ready handshake; the second ciphertext is 66e94bd4ef8a2c3b884cfa59ca342b2e for the all-zero key.
- **Reset mid-operation.** Stimulus: rst pulse at round=4. Required: next cycle in IDLE with in_ready=1, busy=0, round=0, rk_req=0; no out_valid; a following block encrypts correctly.
- **Reset values and spurious rk_valid.** Stimulus: check every output after reset; drive rk_valid=1 in IDLE and DONE. Required: outputs match the Timing reset list; state_q and rnd are unchanged.
- **NR=14.** Stimulus: FIPS-197 C.3 vector (AES-256 key supplied by the bench model). Required: ciphertext 8ea2b7ca516745bfeafc49904b496089; out_valid at cycle 16.

Source files
------------

// File: rtl/aes_round_controller.sv
// Iterative AES encryption sequencer: holds the cipher state, walks it through the
// initial AddRoundKey and NR external-datapath rounds, and hands out the ciphertext.
module aes_round_controller #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_in,
  output logic         dp_final,
  input  logic [127:0] dp_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [3:0]   round
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // Every register holds unless its state's handshake fires, so key stalls and
  // output backpressure need no extra qualification.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    rk_req    = 1'b0;
    dp_final  = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_block;
          rnd_d   = 4'd0;
          fsm_d   = INIT;
        end
      end
      INIT: begin
        rk_req = 1'b1;
        if (rk_valid) begin
          state_d = state_q ^ rk_data;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_req   = 1'b1;
        dp_final = (rnd_q == LAST_RND);
        if (rk_valid) begin
          state_d = dp_out;
          if (rnd_q == LAST_RND) begin
            fsm_d = DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rnd_d = 4'd0;
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign rk_idx    = rnd_q;
  assign round     = rnd_q;
  assign dp_in     = state_q;
  assign out_block = state_q;
  assign busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: reference key schedule and round datapath feed
// an NR=10 and an NR=14 instance; directed vectors plus corner-case sequences.
module tb_aes_round_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, force_rkv, sel;
  logic [127:0] in_block;

  logic         in_ready10, rk_req10, rkv10, dp_final10, out_valid10, busy10;
  logic [3:0]   rk_idx10, round10;
  logic [127:0] rk_data10, dp_in10, dp_out10, out_block10;
  logic         in_ready14, rk_req14, rkv14, dp_final14, out_valid14, busy14;
  logic [3:0]   rk_idx14, round14;
  logic [127:0] rk_data14, dp_in14, dp_out14, out_block14;

  logic [127:0] rk10 [0:15];
  logic [127:0] rk14 [0:15];
  logic [7:0]   sbox_t [0:255];
  int           dly [0:15];
  int           w10, w14;
  int           checks = 0;
  int           errors = 0;

  aes_round_controller #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10), .in_block(in_block),
    .rk_req(rk_req10), .rk_idx(rk_idx10), .rk_valid(rkv10), .rk_data(rk_data10),
    .dp_in(dp_in10), .dp_final(dp_final10), .dp_out(dp_out10),
    .out_valid(out_valid10), .out_ready(out_ready), .out_block(out_block10),
    .busy(busy10), .round(round10)
  );

  aes_round_controller #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready14), .in_block(in_block),
    .rk_req(rk_req14), .rk_idx(rk_idx14), .rk_valid(rkv14), .rk_data(rk_data14),
    .dp_in(dp_in14), .dp_final(dp_final14), .dp_out(dp_out14),
    .out_valid(out_valid14), .out_ready(out_ready), .out_block(out_block14),
    .busy(busy14), .round(round14)
  );

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Reference round: SubBytes, ShiftRows, MixColumns (skipped on the final round), AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) b[rw+4*c] = a[rw+4*((c+rw)%4)];
    for (int c = 0; c < 4; c++) begin
      if (fin) begin
        for (int rw = 0; rw < 4; rw++) a[rw+4*c] = b[rw+4*c];
      end else begin
        a[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
    return r ^ k;
  endfunction

  assign dp_out10  = aes_round(dp_in10, rk_data10, dp_final10);
  assign dp_out14  = aes_round(dp_in14, rk_data14, dp_final14);
  assign rk_data10 = rk10[rk_idx10];
  assign rk_data14 = rk14[rk_idx14];
  assign rkv10     = force_rkv | (rk_req10 && (w10 >= dly[rk_idx10]));
  assign rkv14     = force_rkv | (rk_req14 && (w14 >= dly[rk_idx14]));

  // Key store wait counters: restart whenever a key is delivered.
  always @(posedge clk) begin
    w10 <= (rk_req10 && !rkv10) ? w10 + 1 : 0;
    w14 <= (rk_req14 && !rkv14) ? w14 + 1 : 0;
  end

  logic         o_in_ready, o_rk_req, o_rkv, o_dp_final, o_ov, o_busy;
  logic [3:0]   o_rk_idx, o_round;
  logic [127:0] o_dp_in, o_out_block;
  assign o_in_ready  = sel ? in_ready14  : in_ready10;
  assign o_rk_req    = sel ? rk_req14    : rk_req10;
  assign o_rkv       = sel ? rkv14       : rkv10;
  assign o_dp_final  = sel ? dp_final14  : dp_final10;
  assign o_ov        = sel ? out_valid14 : out_valid10;
  assign o_busy      = sel ? busy14      : busy10;
  assign o_rk_idx    = sel ? rk_idx14    : rk_idx10;
  assign o_round     = sel ? round14     : round10;
  assign o_dp_in     = sel ? dp_in14     : dp_in10;
  assign o_out_block = sel ? out_block14 : out_block10;

  typedef struct {
    logic [127:0] pt;
    logic [255:0] key;
    int           nk;
    int           nr;
    logic [15:0]  mask;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys(input logic [255:0] key, input int nk, input int nr, input logic which);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (which) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else       rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic setup(input vec_t v);
    sel = (v.nr == 14);
    for (int i = 0; i < 16; i++) dly[i] = v.mask[i] ? 3 : 0;
    load_keys(v.key, v.nk, v.nr, sel);
  endtask

  // Cycle 0 is the cycle in which the block is offered; n counts cycles from there.
  task automatic run_block(input vec_t v, input string name);
    int         n, bad_final, bad_idx, bad_stab;
    logic       pwait;
    logic [3:0] pidx;
    in_block = v.pt;
    in_valid = 1'b1;
    out_ready = 1'b1;
    chk({name, "_in_ready"}, 128'(o_in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    in_block = ~v.pt;
    n = 1; bad_final = 0; bad_idx = 0; bad_stab = 0; pwait = 1'b0; pidx = 4'd0;
    while (!o_ov && n < 200) begin
      if (o_dp_final !== (o_rk_req && o_round == 4'(v.nr))) bad_final++;
      if (o_rk_idx !== o_round) bad_idx++;
      if (pwait && o_rk_idx !== pidx) bad_stab++;
      pwait = o_rk_req && !o_rkv;
      pidx = o_rk_idx;
      tick();
      n++;
    end
    chk({name, "_latency"}, 128'(n), 128'(v.lat));
    chk({name, "_ct"}, o_out_block, v.ct);
    chk({name, "_dp_final"}, 128'(bad_final), 128'(0));
    chk({name, "_rk_idx"}, 128'(bad_idx), 128'(0));
    chk({name, "_rk_stable"}, 128'(bad_stab), 128'(0));
    $display("%s: ct=%h out_valid at cycle %0d", name, o_out_block, n);
    tick();
    chk({name, "_post_ov"}, 128'(o_ov), 128'(0));
    chk({name, "_post_in_ready"}, 128'(o_in_ready), 128'(1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [127:0] zkey;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; force_rkv = 1'b0; sel = 1'b0;
    in_block = '0;
    zkey = '0;
    for (int i = 0; i < 16; i++) begin
      rk10[i] = '0; rk14[i] = '0; dly[i] = 0;
    end
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      b = (x == 0) ? 8'h00 : inv;
      sbox_t[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end

    vecs[0] = '{pt: 128'h00112233445566778899aabbccddeeff,
                key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, nk: 4, nr: 10,
                mask: 16'h0000, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat: 12};
    vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff,
                key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, nk: 4, nr: 10,
                mask: 16'h0421, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat: 21};
    vecs[2] = '{pt: 128'h0, key: 256'h0, nk: 4, nr: 10,
                mask: 16'h0000, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, lat: 12};
    vecs[3] = '{pt: 128'h00112233445566778899aabbccddeeff,
                key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                nk: 8, nr: 14,
                mask: 16'h0000, ct: 128'h8ea2b7ca516745bfeafc49904b496089, lat: 16};

    // Reset values; in_valid held high during reset must not be taken.
    setup(vecs[0]);
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    chk("rst_busy_in_reset", 128'(o_busy), 128'(0));
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_in_ready", 128'(o_in_ready), 128'(1));
    chk("rst_rk_req", 128'(o_rk_req), 128'(0));
    chk("rst_rk_idx", 128'(o_rk_idx), 128'(0));
    chk("rst_dp_final", 128'(o_dp_final), 128'(0));
    chk("rst_out_valid", 128'(o_ov), 128'(0));
    chk("rst_out_block", o_out_block, 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_round", 128'(o_round), 128'(0));

    // Spurious rk_valid in IDLE.
    force_rkv = 1'b1;
    tick(); tick(); tick();
    chk("idle_rkv_round", 128'(o_round), 128'(0));
    chk("idle_rkv_state", o_dp_in, 128'(0));
    chk("idle_rkv_busy", 128'(o_busy), 128'(0));
    force_rkv = 1'b0;
    $display("reset/idle sequence done");

    // Table-driven vectors.
    for (int vi = 0; vi < 4; vi++) begin
      setup(vecs[vi]);
      do_reset();
      run_block(vecs[vi], $sformatf("vec%0d", vi));
    end

    // Backpressure with a second all-zero block offered continuously.
    setup(vecs[0]);
    do_reset();
    in_block = vecs[0].pt;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_block = '0;
    n = 1;
    while (!o_ov && n < 100) begin tick(); n++; end
    chk("bp_latency", 128'(n), 128'(12));
    chk("bp_ct", o_out_block, vecs[0].ct);
    force_rkv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_block", o_out_block, vecs[0].ct);
      chk("bp_hold_in_ready", 128'(o_in_ready), 128'(0));
      chk("bp_hold_round", 128'(o_round), 128'(10));
      tick();
    end
    force_rkv = 1'b0;
    load_keys({zkey, zkey}, 4, 10, 1'b0);
    out_ready = 1'b1;
    chk("bp_in_ready_at_handshake", 128'(o_in_ready), 128'(0));
    tick();
    chk("bp_in_ready_after", 128'(o_in_ready), 128'(1));
    chk("bp_ov_after", 128'(o_ov), 128'(0));
    tick();
    in_valid = 1'b0;
    chk("b2b_busy", 128'(o_busy), 128'(1));
    n = 1;
    while (!o_ov && n < 100) begin tick(); n++; end
    chk("b2b_ct", o_out_block, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    $display("backpressure/back-to-back: second ct=%h", o_out_block);
    tick();

    // Reset at round 4, then a fresh block.
    setup(vecs[0]);
    do_reset();
    out_ready = 1'b1;
    in_block = vecs[0].pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (o_round != 4'd4 && n < 50) begin tick(); n++; end
    chk("mid_reach_round4", 128'(o_round), 128'(4));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_in_ready", 128'(o_in_ready), 128'(1));
    chk("mid_busy", 128'(o_busy), 128'(0));
    chk("mid_round", 128'(o_round), 128'(0));
    chk("mid_rk_req", 128'(o_rk_req), 128'(0));
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_ov) n++;
      tick();
    end
    chk("mid_no_out_valid", 128'(n), 128'(0));
    run_block(vecs[0], "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
